// File: rtl/debug_tx_dump_if.sv
// Debug dump bundle: dump request/status, state read ports and UART TX byte handshake.
// master = dump engine side; slave = debug controller, register file, data memory and UART side.
interface debug_tx_dump_if #(
    parameter int NBITS           = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int DM_ADDR_LENGTH  = 32
);
    logic                       send_flag;
    logic                       busy;
    logic                       send_done;
    logic [NBITS-1:0]           pc_value;
    logic [NBITS-1:0]           reg_data;
    logic [NBITS-1:0]           dm_data;
    logic [REG_ADDR_LENGTH-1:0] reg_addr;
    logic [DM_ADDR_LENGTH-1:0]  DM_Addr;
    logic                       tx_start;
    logic [7:0]                 tx_data;
    logic                       tx_done;

    modport master (
        input  send_flag, pc_value, reg_data, dm_data, tx_done,
        output reg_addr, DM_Addr, tx_start, tx_data, busy, send_done
    );

    modport slave (
        output send_flag, pc_value, reg_data, dm_data, tx_done,
        input  reg_addr, DM_Addr, tx_start, tx_data, busy, send_done
    );
endinterface

// File: rtl/debug_tx_dump.sv
// Serializes PC, register file and a data-memory window into MSB-first UART bytes.
// Latency: first tx_start 3 cycles after send_flag; backpressure: each byte waits for tx_done.
module debug_tx_dump #(
    parameter int NBITS           = 32,
    parameter int N_REGS          = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int DM_WORDS        = 16,
    parameter int DM_ADDR_LENGTH  = 32
) (
    input  logic               clk,
    input  logic               reset,
    debug_tx_dump_if.master    bus
);
    localparam int W      = 1 + N_REGS + DM_WORDS;
    localparam int IDX_W  = $clog2(W);
    localparam int BYTES  = NBITS / 8;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(W - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LOAD, SEND, WAIT, DONE} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [BCNT_W-1:0]          bcnt;
    logic [NBITS-1:0]           shreg;
    logic [REG_ADDR_LENGTH-1:0] reg_addr_q;
    logic [DM_ADDR_LENGTH-1:0]  dm_addr_q;
    logic                       tx_start_q;
    logic                       busy_q;
    logic                       send_done_q;

    logic [IDX_W-1:0] idx_nxt;
    logic [31:0]      nxt_ext;
    logic [31:0]      dm_byte_addr;
    logic             nxt_is_reg;
    logic [NBITS-1:0] load_word;

    assign idx_nxt      = idx + IDX_W'(1);
    assign nxt_ext      = 32'(idx_nxt);
    assign dm_byte_addr = (nxt_ext - 32'd1 - 32'(N_REGS)) << 2;
    assign nxt_is_reg   = (nxt_ext <= 32'(N_REGS));

    always_comb begin
        load_word = bus.dm_data;
        if (idx == '0)
            load_word = bus.pc_value;
        else if (32'(idx) <= 32'(N_REGS))
            load_word = bus.reg_data;
    end

    // Addresses are updated on entry to ADDR so they are stable through ADDR and LOAD,
    // which lets a one-cycle synchronous read port deliver data by the LOAD capture edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            reg_addr_q  <= '0;
            dm_addr_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            send_done_q <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            send_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send_flag) begin
                        idx        <= '0;
                        reg_addr_q <= '0;
                        dm_addr_q  <= '0;
                        busy_q     <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: state <= LOAD;
                LOAD: begin
                    shreg      <= load_word;
                    bcnt       <= '0;
                    tx_start_q <= 1'b1;
                    state      <= SEND;
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (bus.tx_done) begin
                        shreg <= shreg << 8;
                        bcnt  <= bcnt + BCNT_W'(1);
                        if (bcnt != LAST_BYTE) begin
                            tx_start_q <= 1'b1;
                            state      <= SEND;
                        end else if (idx != LAST_IDX) begin
                            idx <= idx_nxt;
                            if (nxt_is_reg)
                                reg_addr_q <= REG_ADDR_LENGTH'(nxt_ext - 32'd1);
                            else
                                dm_addr_q <= DM_ADDR_LENGTH'(dm_byte_addr);
                            state <= ADDR;
                        end else begin
                            send_done_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.reg_addr  = reg_addr_q;
    assign bus.DM_Addr   = dm_addr_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = shreg[NBITS-1 -: 8];
    assign bus.busy      = busy_q;
    assign bus.send_done = send_done_q;
endmodule

// File: tb/tb_debug_tx_dump.sv
// Directed bench for debug_tx_dump: default-size instance plus a 2-register / 1-DM-word instance.
module tb_debug_tx_dump;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    debug_tx_dump_if #(.NBITS(32), .REG_ADDR_LENGTH(5), .DM_ADDR_LENGTH(32)) bus ();
    debug_tx_dump_if #(.NBITS(32), .REG_ADDR_LENGTH(5), .DM_ADDR_LENGTH(32)) bus_s ();

    logic tx_done_m = 1'b0;
    logic stray     = 1'b0;
    logic tx_done_s = 1'b0;

    assign bus.tx_done    = tx_done_m | stray;
    assign bus.reg_data   = {27'd0, bus.reg_addr} * 32'h01010101;
    assign bus.dm_data    = 32'hDEAD0000 | bus.DM_Addr;
    assign bus_s.tx_done  = tx_done_s;
    assign bus_s.reg_data = {27'd0, bus_s.reg_addr} * 32'h01010101;
    assign bus_s.dm_data  = 32'hDEAD0000 | bus_s.DM_Addr;

    debug_tx_dump #(.NBITS(32), .N_REGS(32), .REG_ADDR_LENGTH(5), .DM_WORDS(16), .DM_ADDR_LENGTH(32))
        dut (.clk(clk), .reset(reset), .bus(bus));

    debug_tx_dump #(.NBITS(32), .N_REGS(2), .REG_ADDR_LENGTH(5), .DM_WORDS(1), .DM_ADDR_LENGTH(32))
        dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    // UART model and monitor for the default instance
    logic [7:0] bytes[$];
    int         starts[$];
    int         cnt = 0, d_fast = 2, slow_n = 0, done_n = 0, sd_n = 0, sd_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            tx_done_m = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done_m = 1'b1;
                    done_n++;
                end
            end
            if (bus.tx_start === 1'b1) begin
                bytes.push_back(bus.tx_data);
                starts.push_back(cyc);
                cnt = (bytes.size() <= slow_n) ? 100 : d_fast;
            end
            if (bus.send_done === 1'b1) begin
                sd_n++;
                sd_cyc = cyc;
            end
        end
    end

    // UART model and monitor for the small instance (fixed 2-cycle tx_done)
    logic [7:0]  bytes_s[$];
    int          cnt_s = 0, sd_s = 0, sd_s_cyc = 0;
    logic [4:0]  cap_reg = 5'h1f;
    logic [31:0] cap_dm  = 32'hffffffff;

    initial begin
        forever begin
            @(negedge clk);
            tx_done_s = 1'b0;
            if (cnt_s > 0) begin
                cnt_s--;
                if (cnt_s == 0) tx_done_s = 1'b1;
            end
            if (bus_s.tx_start === 1'b1) begin
                bytes_s.push_back(bus_s.tx_data);
                if (bytes_s.size() == 13) begin
                    cap_reg = bus_s.reg_addr;
                    cap_dm  = bus_s.DM_Addr;
                end
                cnt_s = 2;
            end
            if (bus_s.send_done === 1'b1) begin
                sd_s++;
                sd_s_cyc = cyc;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc);
        int          w;
        logic [31:0] word;
        w = i / 4;
        if (w == 0)       word = pc;
        else if (w <= 32) word = 32'(w - 1) * 32'h01010101;
        else              word = 32'hDEAD0000 | 32'((w - 33) * 4);
        word = word >> (8 * (3 - (i % 4)));
        return word[7:0];
    endfunction

    task automatic start_dump(output int k);
        @(posedge clk); #1;
        bus.send_flag = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        bus.send_flag = 1'b0;
    endtask

    task automatic wait_sd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sd_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bytes.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pad_bytes(input int n);
        while (bytes.size() < n) bytes.push_back(8'hxx);
        while (starts.size() < n) starts.push_back(-1);
    endtask

    task automatic test_reset;
        bus.send_flag   = 1'b1;
        bus_s.send_flag = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({bus.tx_start, bus.tx_data, bus.reg_addr, bus.DM_Addr, bus.busy, bus.send_done} !== '0)
                $display("FAIL reset_outputs cycle %0d: got start=%b data=%h ra=%h dm=%h busy=%b done=%b expected all 0",
                         c, bus.tx_start, bus.tx_data, bus.reg_addr, bus.DM_Addr, bus.busy, bus.send_done);
            else n_pass++;
            n_checks++;
            if ({bus_s.busy, bus_s.tx_start} !== 2'b00)
                $display("FAIL reset_small_busy cycle %0d: got %b expected 00", c, {bus_s.busy, bus_s.tx_start});
            else n_pass++;
        end
        bus.send_flag   = 1'b0;
        bus_s.send_flag = 1'b0;
        reset           = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_byte_order;
        int k, sd0;
        bit ok;
        logic [7:0] exp4 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        d_fast = 2; slow_n = 0;
        bus.pc_value = 32'h12345678;
        bytes.delete(); starts.delete();
        sd0 = sd_n;
        start_dump(k);
        wait_bytes(4, 100, ok);
        n_checks++;
        if (!ok) $display("FAIL order_timeout: got %0d bytes expected 4", bytes.size()); else n_pass++;
        pad_bytes(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bytes[i] !== exp4[i]) $display("FAIL order_byte%0d: got %h expected %h", i, bytes[i], exp4[i]);
            else n_pass++;
        end
        n_checks++;
        if (starts[0] !== k + 3) $display("FAIL first_start_latency: got %0d expected %0d", starts[0] - k, 3);
        else n_pass++;
        wait_sd(sd0 + 1, 2000, ok);
        n_checks++;
        if (!ok || sd_cyc - k != 687) $display("FAIL dump_time_d2: got %0d expected 687", sd_cyc - k);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_full_dump;
        int k, sd0, bad;
        bit ok;
        d_fast = 1; slow_n = 0;
        bus.pc_value = 32'hCAFEF00D;
        bytes.delete(); starts.delete();
        sd0 = sd_n;
        start_dump(k);
        wait_sd(sd0 + 1, 3000, ok);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (sd_n - sd0 != 1) $display("FAIL full_send_done_count: got %0d expected 1", sd_n - sd0); else n_pass++;
        n_checks++;
        if (bytes.size() != 196) $display("FAIL full_byte_count: got %0d expected 196", bytes.size()); else n_pass++;
        pad_bytes(196);
        n_checks++;
        if ({bytes[0], bytes[1], bytes[2], bytes[3]} !== 32'hCAFEF00D)
            $display("FAIL full_pc_word: got %h expected cafef00d", {bytes[0], bytes[1], bytes[2], bytes[3]});
        else n_pass++;
        n_checks++;
        if ({bytes[24], bytes[25], bytes[26], bytes[27]} !== 32'h05050505)
            $display("FAIL full_reg5: got %h expected 05050505", {bytes[24], bytes[25], bytes[26], bytes[27]});
        else n_pass++;
        n_checks++;
        if ({bytes[132], bytes[133], bytes[134], bytes[135]} !== 32'hDEAD0000)
            $display("FAIL full_dm0: got %h expected dead0000", {bytes[132], bytes[133], bytes[134], bytes[135]});
        else n_pass++;
        n_checks++;
        if ({bytes[192], bytes[193], bytes[194], bytes[195]} !== 32'hDEAD003C)
            $display("FAIL full_last_word: got %h expected dead003c", {bytes[192], bytes[193], bytes[194], bytes[195]});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 196; i++) if (bytes[i] !== exp_byte(i, 32'hCAFEF00D)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL full_frame_content: got %0d wrong bytes expected 0", bad); else n_pass++;
        n_checks++;
        if (sd_cyc - k != 491) $display("FAIL dump_time_d1: got %0d expected 491", sd_cyc - k); else n_pass++;
    endtask

    task automatic test_protocol;
        int k, sd0, bad, n;
        bit ok;
        d_fast = 1; slow_n = 8;
        bus.pc_value = 32'h0BADBEEF;
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        n_checks++;
        if ({bus.busy, bus.tx_start} !== 2'b00)
            $display("FAIL stray_done_idle: got %b expected 00", {bus.busy, bus.tx_start});
        else n_pass++;
        bytes.delete(); starts.delete();
        sd0 = sd_n;
        start_dump(k);
        n = 0;
        for (int i = 0; i < 2000 && n < 3; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) n++;
        end
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (50) @(posedge clk);
        #1 bus.send_flag = 1'b1;
        @(posedge clk); #1 bus.send_flag = 1'b0;
        wait_sd(sd0 + 1, 5000, ok);
        repeat (20) @(posedge clk);
        #1;
        slow_n = 0;
        n_checks++;
        if (sd_n - sd0 != 1) $display("FAIL proto_send_done_count: got %0d expected 1", sd_n - sd0); else n_pass++;
        n_checks++;
        if (bytes.size() != 196) $display("FAIL proto_byte_count: got %0d expected 196", bytes.size()); else n_pass++;
        pad_bytes(196);
        bad = 0;
        for (int i = 0; i < 196; i++) if (bytes[i] !== exp_byte(i, 32'h0BADBEEF)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL proto_frame_content: got %0d wrong bytes expected 0", bad); else n_pass++;
        n_checks++;
        if (sd_cyc - k != 1283) $display("FAIL proto_dump_time: got %0d expected 1283", sd_cyc - k); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int k, sd0, d0;
        bit ok;
        logic [7:0] exp4 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        d_fast = 2; slow_n = 0;
        bus.pc_value = 32'h12345678;
        sd0 = sd_n;
        d0  = done_n;
        start_dump(k);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (done_n >= d0 + 10) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL mid_wait_10_done: got %0d expected 10", done_n - d0); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.tx_start, bus.tx_data, bus.reg_addr, bus.DM_Addr, bus.busy, bus.send_done} !== '0)
            $display("FAIL mid_reset_outputs: got start=%b data=%h ra=%h dm=%h busy=%b done=%b expected all 0",
                     bus.tx_start, bus.tx_data, bus.reg_addr, bus.DM_Addr, bus.busy, bus.send_done);
        else n_pass++;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bytes.delete(); starts.delete();
        start_dump(k);
        wait_bytes(4, 100, ok);
        pad_bytes(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bytes[i] !== exp4[i]) $display("FAIL restart_byte%0d: got %h expected %h", i, bytes[i], exp4[i]);
            else n_pass++;
        end
        n_checks++;
        if (starts[0] !== k + 3) $display("FAIL restart_latency: got %0d expected 3", starts[0] - k); else n_pass++;
        wait_sd(sd0 + 1, 2000, ok);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (sd_n - sd0 != 1) $display("FAIL mid_send_done_count: got %0d expected 1", sd_n - sd0); else n_pass++;
    endtask

    task automatic test_small;
        int k;
        logic [7:0] exp_s [16] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h01, 8'h01, 8'h01, 8'h01, 8'hDE, 8'hAD, 8'h00, 8'h00};
        bus_s.pc_value = 32'hA1B2C3D4;
        bytes_s.delete();
        @(posedge clk); #1;
        bus_s.send_flag = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        bus_s.send_flag = 1'b0;
        for (int i = 0; i < 300 && sd_s == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (sd_s != 1) $display("FAIL small_send_done_count: got %0d expected 1", sd_s); else n_pass++;
        n_checks++;
        if (bytes_s.size() != 16) $display("FAIL small_byte_count: got %0d expected 16", bytes_s.size()); else n_pass++;
        while (bytes_s.size() < 16) bytes_s.push_back(8'hxx);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (bytes_s[i] !== exp_s[i]) $display("FAIL small_byte%0d: got %h expected %h", i, bytes_s[i], exp_s[i]);
            else n_pass++;
        end
        n_checks++;
        if (cap_reg !== 5'd1) $display("FAIL small_last_reg_addr: got %0d expected 1", cap_reg); else n_pass++;
        n_checks++;
        if (cap_dm !== 32'd0) $display("FAIL small_last_dm_addr: got %h expected 0", cap_dm); else n_pass++;
        n_checks++;
        if (sd_s_cyc - k != 57) $display("FAIL small_dump_time: got %0d expected 57", sd_s_cyc - k); else n_pass++;
    endtask

    initial begin
        bus.send_flag   = 1'b0;
        bus.pc_value    = 32'h0;
        bus_s.send_flag = 1'b0;
        bus_s.pc_value  = 32'h0;
        test_reset();
        test_byte_order();
        test_full_dump();
        test_protocol();
        test_reset_mid();
        test_small();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/debug_tx_dump.md
# debug_tx_dump

Serializes the halted processor's debug state (PC, register file, a window of data memory) into bytes for the UART transmitter. It is the transmit-side counterpart of the debug controller: `debug_control` loads programs from `rx_Data`/`rx_done`, raises `send_flag` after `halt_flag`, and waits for `send_done`. This block answers that request by dumping state to the host. It sits between `debug_control`, the register file / data memory read ports, and the UART TX.

## Interface

Parameters:

- `NBITS`, 32: word width. Must be a multiple of 8.
- `N_REGS`, 32: number of registers dumped.
- `REG_ADDR_LENGTH`, 5: width of `reg_addr`.
- `DM_WORDS`, 16: number of data-memory words dumped, starting at address 0.
- `DM_ADDR_LENGTH`, 32: width of `DM_Addr` (byte address).

Ports:

- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `send_flag`, in, 1: dump request pulse from `debug_control`. Sampled only in IDLE.
- `pc_value`, in, `NBITS`: current PC.
- `reg_data`, in, `NBITS`: register file read data for `reg_addr`.
- `dm_data`, in, `NBITS`: data memory read data for `DM_Addr`.
- `tx_done`, in, 1: UART TX one-cycle pulse, meaning the current byte has finished.
- `reg_addr`, out, `REG_ADDR_LENGTH`: register file read address (registered).
- `DM_Addr`, out, `DM_ADDR_LENGTH`: data memory byte address (registered, word-aligned).
- `tx_start`, out, 1: one-cycle pulse that starts a UART byte.
- `tx_data`, out, 8: byte to transmit. Equals the top byte of the shift register.
- `busy`, out, 1: high in every state except IDLE.
- `send_done`, out, 1: one-cycle pulse when the whole dump has been sent.

## Operation

- **Frame layout:** `W = 1 + N_REGS + DM_WORDS` words.
  - Word index 0 is `pc_value`.
  - Indices 1..`N_REGS` are registers 0..`N_REGS`-1.
  - The remaining indices are DM words 0..`DM_WORDS`-1.
  - Each word is sent as `NBITS/8` bytes, MSB first.
  - Defaults give 49 words, 196 bytes.
- **Counters:**
  - Word index width is `$clog2(W)` bits.
  - Byte counter width is `$clog2(NBITS/8)` bits.
  - For a DM word, `DM_Addr = (idx - 1 - N_REGS) * 4`, zero-extended.
  - For a register word, `reg_addr = idx - 1`, truncated to `REG_ADDR_LENGTH`.
  - Address outputs hold their last value outside their range.
- **FSM states:** IDLE, ADDR, LOAD, SEND, WAIT, DONE.
  - IDLE: when `send_flag`=1, clear the word index, `reg_addr` and `DM_Addr` to 0, then go to ADDR.
  - ADDR: drive `reg_addr`/`DM_Addr` for the current index, then go to LOAD. Sources may be combinational or one-cycle synchronous read.
  - LOAD: capture the selected source (`pc_value` / `reg_data` / `dm_data`) into the shift register, clear the byte counter, then go to SEND.
  - SEND: `tx_start`=1 for this cycle only, then go to WAIT.
  - WAIT: stay until `tx_done`. On `tx_done`, shift left 8 bits and increment the byte counter.
    - Bytes remain: go to SEND.
    - Last byte of the word, not the last word: increment the index and go to ADDR.
    - Last byte of the last word: go to DONE.
  - DONE: `send_done`=1 for one cycle, then go to IDLE.
- **Ignored inputs:**
  - `send_flag` outside IDLE.
  - `tx_done` outside WAIT. A `tx_done` in the same cycle as `tx_start` is also ignored.
- **Reset:** `reset` at any time forces IDLE on the next edge and clears all registers. A byte already started in the UART is not aborted or compensated.
- **Reset values:** `tx_start`=0, `tx_data`=0x00, `reg_addr`=0, `DM_Addr`=0, `busy`=0, `send_done`=0.

## Timing

- `send_flag` sampled at edge k gives ADDR in cycle k+1, LOAD in k+2, and `tx_start` high in cycle k+3.
- Per word: 2 cycles of overhead (ADDR, LOAD).
- Per byte: 1 SEND cycle plus the WAIT cycles until `tx_done`.
- After a `tx_done` that does not end the word, the next `tx_start` appears in the following cycle.
- `tx_data` is stable from SEND until the `tx_done` that ends its WAIT.
- `send_done` is high in the cycle after the final `tx_done` is sampled.
- `busy` falls in the cycle after `send_done`.
- With `tx_done` arriving d cycles after `tx_start` (d ≥ 1), the total dump time from `send_flag` to `send_done` is 2W + (NBITS/8)·W·(d+1) + 1 cycles.

## Test plan

- **Reset:** hold `reset` for 3 cycles with `send_flag`=1. All outputs must stay at their reset values and `busy` must stay 0.
- **Byte order:** `pc_value`=0x12345678, `tx_done` 2 cycles after each `tx_start`.
  - The first four `tx_data` values at `tx_start` must be 0x12, 0x34, 0x56, 0x78.
  - The first `tx_start` must appear 3 cycles after `send_flag`.
- **Full dump (default parameters):** `reg_data` = `reg_addr`·0x01010101, `dm_data` = 0xDEAD0000 | `DM_Addr`.
  - Exactly 196 `tx_start` pulses.
  - Reg 5 is sent as 05 05 05 05.
  - The last word is DE AD 00 3C.
  - Exactly one `send_done`.
- **Protocol robustness:**
  - `send_flag` pulsed mid-dump: ignored.
  - Stray `tx_done` in IDLE/SEND: ignored.
  - `tx_done` delayed 100 cycles: `tx_start` remains a single pulse and byte count/order are unchanged.
- **Reset mid-stream:** assert `reset` after the 10th `tx_done`.
  - The block returns to IDLE with outputs at reset values.
  - The next `send_flag` restarts from the PC's MSB byte.
- **Small configuration:** `N_REGS`=2, `DM_WORDS`=1.
  - Exactly 16 bytes are sent.
  - `DM_Addr`=0 and `reg_addr`=1 when the last word is captured.
  - `send_done` arrives per the timing formula.
